// File: rtl/alu_wide_sequencer_pkg.sv
// alu_seq_pkg: op/state types and the per-op ALU control table for alu_wide_sequencer
package alu_seq_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR, OP_NOTA} op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {CIN_ZERO, CIN_ONE, CIN_FLAG} cin_t;
  typedef struct packed {
    logic       mode;
    logic [3:0] sel;
    cin_t       cin;
    logic       is_logic;
  } op_info_t;
  // Indexed by op_t; selector values are as seen at the ALU port
  localparam op_info_t OP_TABLE [8] = '{
    '{1'b0, 4'b0110, CIN_ZERO, 1'b0},
    '{1'b0, 4'b0110, CIN_FLAG, 1'b0},
    '{1'b0, 4'b1001, CIN_ONE,  1'b0},
    '{1'b0, 4'b1001, CIN_FLAG, 1'b0},
    '{1'b1, 4'b0100, CIN_ZERO, 1'b1},
    '{1'b1, 4'b0001, CIN_ZERO, 1'b1},
    '{1'b1, 4'b1001, CIN_ZERO, 1'b1},
    '{1'b1, 4'b1111, CIN_ZERO, 1'b1}
  };
endpackage

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs NBYTES-wide ops through an external 8-bit ALU, LSB first, chaining carry
module alu_wide_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NBYTES           = 2,
  parameter bit CARRY_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [8*NBYTES-1:0]   op_a_i,
  input  logic [8*NBYTES-1:0]   op_b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [8*NBYTES-1:0]   result_o,
  output logic                  carry_flag_o,
  output logic                  zero_flag_o,
  output logic                  alu_mode_o,
  output logic [3:0]            alu_selector_o,
  output logic [7:0]            alu_a_o,
  output logic [7:0]            alu_b_o,
  output logic                  alu_carry_in_o,
  input  logic [7:0]            alu_f_i,
  input  logic                  alu_carry_out_i
);
  localparam int W = 8 * NBYTES;
  state_t         state_q, state_d;
  op_t            op_q, op_d, op_in;
  logic [W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]     idx_q, idx_d;
  logic           c_q, c_d, zacc_q, zacc_d, cf_q, cf_d, zf_q, zf_d;
  logic           run, last, cout, fz, c_init;
  assign op_in  = op_t'(op_i);
  assign run    = state_q == S_RUN;
  assign last   = idx_q == 2'(NBYTES - 1);
  assign cout   = alu_carry_out_i ^ CARRY_ACTIVE_LOW;
  assign fz     = alu_f_i == 8'h00;
  assign c_init = OP_TABLE[op_in].cin == CIN_ONE || (OP_TABLE[op_in].cin == CIN_FLAG && cf_q);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  always_comb
    state_d = state_q == S_IDLE ? (start_i ? S_RUN : S_IDLE) :
              state_q == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
  always_comb begin
    busy_o         = state_q != S_IDLE;
    done_o         = state_q == S_DONE;
    alu_mode_o     = run ? OP_TABLE[op_q].mode : 1'b1;
    alu_selector_o = run ? OP_TABLE[op_q].sel : 4'b0000;
    alu_a_o        = run ? a_q[{idx_q, 3'b000} +: 8] : 8'h00;
    alu_b_o        = run ? b_q[{idx_q, 3'b000} +: 8] : 8'h00;
    alu_carry_in_o = (run & c_q) ^ CARRY_ACTIVE_LOW;
  end
  // Flags are committed on the last pass so they are already valid while Done is high
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    c_d      = c_q;
    zacc_d   = zacc_q;
    result_d = result_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    if (state_q == S_IDLE && start_i) begin
      op_d   = op_in;
      a_d    = op_a_i;
      b_d    = op_b_i;
      idx_d  = 2'd0;
      zacc_d = 1'b1;
      c_d    = c_init;
    end else if (run) begin
      result_d[{idx_q, 3'b000} +: 8] = alu_f_i;
      c_d    = cout;
      zacc_d = zacc_q & fz;
      idx_d  = idx_q + 2'd1;
      cf_d   = last ? (~OP_TABLE[op_q].is_logic & cout) : cf_q;
      zf_d   = last ? (zacc_q & fz) : zf_q;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= 2'd0;
      c_q      <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      zacc_q   <= zacc_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
    end
  assign result_o     = result_q;
  assign carry_flag_o = cf_q;
  assign zero_flag_o  = zf_q;
endmodule
